moore_seq_det: RTL and testbench

Moore-type serial sequence detector: samples one bit per clock on `data_in` and asserts `data_out` for one full cycle after the pattern 0110 has been received. Overlapping occurrences are detected. It is a leaf block in the FSM library, fed by a serial bit stream and driving a registered detect flag to downstream control logic.

---
 rtl/moore_seq_det_pkg.sv | 20 ++
 rtl/moore_seq_det.sv | 56 +++++
 tb/tb_moore_seq_det.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/moore_seq_det_pkg.sv
// Shared types and constants for the 0110 Moore sequence detector.
package moore_seq_det_pkg;

  // The state name is the longest suffix of the pattern matched so far.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  localparam logic [3:0] PATTERN = 4'b0110;
  localparam int         PAT_LEN = 4;

  function automatic logic is_detect(input state_e s);
    return (s == S4);
  endfunction

endpackage

// File: rtl/moore_seq_det.sv
// Moore detector for serial pattern 0110 with overlap; registered detect flag.
// Optional saturating detection counter enabled by MOORE_SEQ_DET_CNT_EN.
module moore_seq_det
  import moore_seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
`ifdef MOORE_SEQ_DET_CNT_EN
  output logic [CNT_W-1:0] det_count,
`endif
  output logic             data_out
);

  state_e r_state;
  state_e w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S0;
    else     r_state <= w_next;
  end

  // PATTERN[PAT_LEN-1] is the first bit received.
  always_comb begin
    w_next = S0;
    case (r_state)
      S0: w_next = (data_in == PATTERN[PAT_LEN-1]) ? S1 : S0;
      S1: w_next = (data_in == PATTERN[PAT_LEN-2]) ? S2 : S1;
      S2: w_next = (data_in == PATTERN[PAT_LEN-3]) ? S3 : S1;
      S3: w_next = (data_in == PATTERN[PAT_LEN-4]) ? S4 : S0;
      S4: w_next = data_in ? S2 : S1;
      default: w_next = S0;
    endcase
  end

  always_comb begin
    data_out = is_detect(r_state);
  end

`ifdef MOORE_SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit = (w_next == S4);

  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= '0;
    else if (w_hit && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end

  assign det_count = r_cnt;
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Bench for moore_seq_det: directed vector table, hand sequences, random vs. suffix model.
module tb_moore_seq_det;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic data_in;
  logic data_out;
`ifdef MOORE_SEQ_DET_CNT_EN
  logic [CNT_W-1:0] det_count;
`endif

  always #5 clk = ~clk;

  moore_seq_det #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
`ifdef MOORE_SEQ_DET_CNT_EN
    .det_count(det_count),
`endif
    .data_out (data_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference: last bits since reset; detect when the last four equal 0110.
  bit  hist[$];
  bit  m_out = 1'b0;
  int  m_cnt = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic d);
    rst = r;
    data_in = d;
    @(posedge clk);
    if (r) begin
      hist.delete();
      m_cnt = 0;
      m_out = 1'b0;
    end else begin
      hist.push_back(d);
      if (hist.size() > 4) void'(hist.pop_front());
      m_out = (hist.size() == 4) && !hist[0] && hist[1] && hist[2] && !hist[3];
      if (m_out && m_cnt < CNT_MAX) m_cnt++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic r;
    logic d;
    logic exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic d, input logic e);
    vec_t v;
    v.r = r; v.d = d; v.exp_out = e;
    vecs.push_back(v);
  endtask

  task automatic add_seq(input string bits, input string exps);
    for (int i = 0; i < bits.len(); i++)
      add(1'b0, bits[i] == "1", exps[i] == "1");
  endtask

  initial begin
    rst = 1'b1;
    data_in = 1'b1;
    @(negedge clk);

    // Reset held two edges with data_in = 1
    add(1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0);
    // Basic detection, then pulse drops
    add_seq("01101", "00010");
    add(1'b1, 1'b0, 1'b0);
    // Overlap
    add_seq("0110110", "0001001");
    add(1'b1, 1'b0, 1'b0);
    // Long stream
    add_seq("0011011010110", "0000100100001");
    add(1'b1, 1'b0, 1'b0);
    // Near misses
    add_seq("0111010010", "0000000000");
    add(1'b1, 1'b0, 1'b0);
    // Mid-sequence reset discards partial match
    add_seq("011", "000");
    add(1'b1, 1'b0, 1'b0);
    add_seq("0", "0");
    add_seq("0110", "0001");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].d);
      chk($sformatf("vec%0d_out", i), data_out, vecs[i].exp_out);
`ifdef MOORE_SEQ_DET_CNT_EN
      chk($sformatf("vec%0d_cnt", i), det_count, m_cnt);
`endif
    end

    // Moore check: changing data_in between edges must not move data_out.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
    chk("moore_hold_pre", data_out, 1);
    data_in = 1'b1; #1;
    chk("moore_hold_d1", data_out, 1);
    data_in = 1'b0; #1;
    chk("moore_hold_d0", data_out, 1);
    step(1'b0, 1'b0);
    chk("one_cycle_pulse", data_out, 0);

`ifdef MOORE_SEQ_DET_CNT_EN
    // Saturation: detections every 3 cycles exceed the counter range.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3 * (CNT_MAX + 10); i++) step(1'b0, (i % 3) != 2);
    chk("cnt_saturate", det_count, CNT_MAX);
    chk("cnt_model_sat", det_count, m_cnt);
    step(1'b1, 1'b0);
    chk("cnt_reset", det_count, 0);
`endif

    // Randomized stream against the suffix model.
    for (int i = 0; i < 3000; i++) begin
      logic r, d;
      r = ($urandom_range(0, 79) == 0);
      d = ($urandom_range(0, 99) < 55);
      step(r, d);
      chk("rand_out", data_out, m_out);
`ifdef MOORE_SEQ_DET_CNT_EN
      chk("rand_cnt", det_count, m_cnt);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
